// File: rtl/ht_init_ctrl_pkg.sv
// Shared types and constants for the hash-table RAM-clear sequencer.
// Imported by the controller and its in-flight command counter.
package ht_init_ctrl_pkg;

    typedef enum logic [2:0] {
        READY     = 3'd0,
        DRAIN     = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        ERROR     = 3'd4
    } ht_init_state_t;

    localparam int HT_INIT_CNT_W = 8;

    // Counter width able to hold values 0..n-1; never narrower than one bit.
    function automatic int ht_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ht_inflight_cnt.sv
// Up/down count of commands accepted but not yet returned as results.
// Saturates at zero and exposes the next-cycle value so callers can react without delay.
module ht_inflight_cnt
    import ht_init_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_next_o
);

    localparam int CNT_W = ht_cnt_width(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc_i && !dec_i) begin
            count_next = count_reg + 1'b1;
        end else if (dec_i && !inc_i && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else begin
            // A result with nothing in flight means an upstream protocol bug.
            underflow_a: assert (!(dec_i && !inc_i && (count_reg == '0)));
            count_reg <= count_next;
        end
    end

    assign full_o       = (count_reg >= CNT_MAX);
    assign empty_next_o = (count_next == '0);

endmodule

// File: rtl/ht_init_ctrl.sv
// Sequences head/data table RAM clears after reset and on request, and gates the
// command handshake into calc_hash while a clear is scheduled or running.
module ht_init_ctrl
    import ht_init_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16,
    parameter int TIMEOUT_CYCLES  = 65536,
    parameter int AUTO_CLEAR      = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_req_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    input  logic                     res_valid_i,
    input  logic                     res_ready_i,
    output logic                     head_clear_run_o,
    input  logic                     head_clear_done_i,
    output logic                     data_clear_run_o,
    input  logic                     data_clear_done_i,
    output logic                     init_done_o,
    output logic                     busy_o,
    output logic                     timeout_err_o,
    output logic [HT_INIT_CNT_W-1:0] clear_cnt_o
);

    localparam int TO_W = ht_cnt_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam ht_init_state_t RESET_STATE = (AUTO_CLEAR != 0) ? DRAIN : READY;

    ht_init_state_t           state_reg, state_next;
    logic                     head_done_reg, head_done_next;
    logic                     data_done_reg, data_done_next;
    logic                     pending_reg, pending_next;
    logic                     timeout_err_reg, timeout_err_next;
    logic [TO_W-1:0]          to_cnt_reg, to_cnt_next;
    logic [HT_INIT_CNT_W-1:0] clear_cnt_reg, clear_cnt_next;

    logic gate_open;
    logic inflight_full;
    logic inflight_empty_next;
    logic cmd_accept;
    logic res_accept;
    logic head_seen;
    logic data_seen;

    assign gate_open   = (state_reg == READY) && !inflight_full;
    assign cmd_valid_o = cmd_valid_i & gate_open;
    assign cmd_ready_o = cmd_ready_i & gate_open;
    assign cmd_accept  = cmd_valid_o & cmd_ready_i;
    assign res_accept  = res_valid_i & res_ready_i;

    ht_inflight_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_inflight (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inc_i        (cmd_accept),
        .dec_i        (res_accept),
        .full_o       (inflight_full),
        .empty_next_o (inflight_empty_next)
    );

    // Strobes in the current cycle count as seen so completion costs no extra cycle.
    assign head_seen = head_done_reg | head_clear_done_i;
    assign data_seen = data_done_reg | data_clear_done_i;

    always_comb begin
        state_next       = state_reg;
        head_done_next   = head_done_reg;
        data_done_next   = data_done_reg;
        pending_next     = pending_reg;
        timeout_err_next = timeout_err_reg;
        to_cnt_next      = to_cnt_reg;
        clear_cnt_next   = clear_cnt_reg;

        case (state_reg)
            READY: begin
                if (clear_req_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Includes a result retiring this cycle, so START follows the last result.
                if (inflight_empty_next) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                head_done_next = head_seen;
                data_done_next = data_seen;
                to_cnt_next    = to_cnt_reg + 1'b1;
                if (clear_req_i) begin
                    pending_next = 1'b1;
                end
                if (head_seen && data_seen) begin
                    clear_cnt_next = clear_cnt_reg + 1'b1;
                    state_next     = (pending_reg || clear_req_i) ? DRAIN : READY;
                    pending_next   = 1'b0;
                end else if (to_cnt_reg == TO_LAST) begin
                    timeout_err_next = 1'b1;
                    pending_next     = 1'b0;
                    state_next       = ERROR;
                end
            end
            ERROR: begin
                if (clear_req_i) begin
                    state_next = DRAIN;
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase

        // Fresh bookkeeping for every clear attempt, visible from the START cycle on.
        if (state_next == START) begin
            head_done_next   = 1'b0;
            data_done_next   = 1'b0;
            to_cnt_next      = '0;
            timeout_err_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= RESET_STATE;
            head_done_reg   <= 1'b0;
            data_done_reg   <= 1'b0;
            pending_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
            to_cnt_reg      <= '0;
            clear_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            head_done_reg   <= head_done_next;
            data_done_reg   <= data_done_next;
            pending_reg     <= pending_next;
            timeout_err_reg <= timeout_err_next;
            to_cnt_reg      <= to_cnt_next;
            clear_cnt_reg   <= clear_cnt_next;
        end
    end

    assign head_clear_run_o = (state_reg == START);
    assign data_clear_run_o = (state_reg == START);
    assign init_done_o      = (state_reg == READY);
    assign busy_o           = (state_reg == DRAIN) || (state_reg == START) ||
                              (state_reg == WAIT_DONE);
    assign timeout_err_o    = timeout_err_reg;
    assign clear_cnt_o      = clear_cnt_reg;

endmodule

// File: doc/ht_init_ctrl.md
Name: ht_init_ctrl

Overview:
Sequences RAM clearing of the hash table. It drives clear_ram_run to head_table and data_table, automatically after reset and on software request, and waits for both done strobes. While a clear is pending or in progress it gates the ht_cmd handshake in front of calc_hash. It tracks in-flight commands so a requested clear starts only after the pipeline has drained.

Parameters:
MAX_OUTSTANDING, 16, maximum commands in flight between cmd acceptance and result handshake; further commands are back-pressured.
TIMEOUT_CYCLES, 65536, maximum cycles in WAIT_DONE before a timeout error is declared.
AUTO_CLEAR, 1, when 1 a clear runs after every reset; when 0 the block comes out of reset in READY.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
clear_req_i  in  1  single-cycle software clear request
cmd_valid_i  in  1  upstream command valid (from ht_cmd_in.valid)
cmd_ready_o  out  1  upstream ready (to ht_cmd_in.ready)
cmd_valid_o  out  1  downstream valid (to calc_hash)
cmd_ready_i  in  1  downstream ready (from calc_hash)
res_valid_i  in  1  result valid (ht_res_out.valid)
res_ready_i  in  1  result ready (ht_res_out.ready)
head_clear_run_o  out  1  one-cycle clear pulse to head_table
head_clear_done_i  in  1  one-cycle done strobe from head_table
data_clear_run_o  out  1  one-cycle clear pulse to data_table
data_clear_done_i  in  1  one-cycle done strobe from data_table
init_done_o  out  1  high only in READY
busy_o  out  1  high in DRAIN, START, WAIT_DONE
timeout_err_o  out  1  sticky; set on timeout, cleared on entry to START
clear_cnt_o  out  8  number of completed clears, wraps 255->0

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state = DRAIN if AUTO_CLEAR else READY. All run outputs, timeout_err_o and clear_cnt_o = 0. outstanding = 0; pending = 0.
- States and transitions:
  - READY: gate open. clear_req_i -> DRAIN.
  - DRAIN: gate closed. outstanding == 0 -> START (same-cycle check; zero wait when already empty).
  - START: both run outputs = 1 for exactly this cycle. Clear done flags, clear the timeout counter, clear timeout_err_o. -> WAIT_DONE.
  - WAIT_DONE: each done strobe sets its sticky flag. When both flags are set (including strobes in the current cycle): clear_cnt_o++, then go to DRAIN if pending else READY, and clear pending. If the timeout counter reaches TIMEOUT_CYCLES-1 first: set timeout_err_o -> ERROR.
  - ERROR: gate closed; init_done_o = 0, busy_o = 0. clear_req_i -> DRAIN.
- Done strobes arriving in READY, DRAIN or ERROR are ignored.
- Gate logic (combinational): open = (state == READY) && (outstanding < MAX_OUTSTANDING).
  - cmd_valid_o = cmd_valid_i & open
  - cmd_ready_o = cmd_ready_i & open
  - No added latency, no buffering.
- outstanding counter:
  - width $clog2(MAX_OUTSTANDING+1)
  - +1 on cmd_valid_o & cmd_ready_i; -1 on res_valid_i & res_ready_i; both in one cycle -> unchanged
  - decrement at 0 saturates at 0 and fires a simulation assertion
- clear_req_i handling by state:
  - DRAIN or START: ignored (clear already scheduled).
  - WAIT_DONE: sets pending.
  - ERROR: retries the clear.
- Reset during any state aborts the sequence immediately. No run pulse is emitted in the reset cycle.

Decomposition:
- hash_table package gets:
  - ht_init_state_t enum: READY, DRAIN, START, WAIT_DONE, ERROR
  - HT_INIT_CNT_W = 8
- One sub-module, ht_inflight_cnt: the outstanding up/down counter with saturation and a full flag.
- hash_table_top instantiates ht_init_ctrl, replacing the constant-0 clear_ram_run ties and inserting the block on the ht_cmd handshake.

Test Plan:
1. Reset release with AUTO_CLEAR=1, done strobes 5 and 9 cycles after run -> one run pulse each; init_done_o rises the cycle after the second done; clear_cnt_o = 1; cmd_ready_o = 0 throughout.
2. In READY, accept 3 commands, then clear_req_i -> state holds DRAIN until 3 result handshakes complete; run pulses occur the cycle after the third result.
3. MAX_OUTSTANDING=4, downstream always ready, no results -> exactly 4 commands accepted, then cmd_ready_o = 0. One result handshake -> one more command accepted.
4. TIMEOUT_CYCLES=32, only head done arrives -> timeout_err_o = 1 after 32 WAIT_DONE cycles; gate stays closed. clear_req_i -> new run pulses and timeout_err_o clears.
5. clear_req_i during WAIT_DONE -> after both dones a second DRAIN/START occurs; clear_cnt_o ends at 2. Both dones in the same cycle are accepted.
6. Assert rst_i mid-WAIT_DONE -> outputs return to reset values asynchronously; a fresh sequence starts after release; clear_cnt_o = 0.
